// File: rtl/banco_registradores_pkg.sv
// Shared constants and types for the register file (banco_registradores).
// Default geometry: 32 registers of 32 bits, 5-bit indices; register 0 reads as zero.
package banco_registradores_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 5;
    localparam int unsigned NUM_REGS_DEF   = 32;
    localparam int unsigned REG_ZERO       = 0;

    typedef logic [ADDR_WIDTH_DEF-1:0] reg_idx_t;
    typedef logic [DATA_WIDTH_DEF-1:0] reg_data_t;

endpackage : banco_registradores_pkg

// File: rtl/banco_registradores_read_port.sv
// One combinational read port of the register file.
// Index 0 always returns zero. With BANCO_REGISTRADORES_BYPASS_EN defined, a
// pending write (wr_en=1, wr_idx!=0) to the addressed register is forwarded so
// writeback and decode can share a cycle; otherwise only stored data is returned.
module banco_registradores_read_port
    import banco_registradores_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned NUM_REGS   = NUM_REGS_DEF
) (
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs,
    input  logic [ADDR_WIDTH-1:0]               idx,
`ifdef BANCO_REGISTRADORES_BYPASS_EN
    input  logic                                wr_en,
    input  logic [ADDR_WIDTH-1:0]               wr_idx,
    input  logic [DATA_WIDTH-1:0]               wr_data,
`endif
    output logic [DATA_WIDTH-1:0]               rdata
);

    localparam logic [ADDR_WIDTH-1:0] IDX_ZERO = ADDR_WIDTH'(REG_ZERO);

    // Select stored contents, masking register 0 and optionally forwarding a write.
    always_comb begin
        rdata = regs[idx];
        if (idx == IDX_ZERO) begin
            rdata = '0;
        end
`ifdef BANCO_REGISTRADORES_BYPASS_EN
        else if (wr_en && (wr_idx != IDX_ZERO) && (wr_idx == idx)) begin
            rdata = wr_data;
        end
`endif
    end

endmodule : banco_registradores_read_port

// File: rtl/banco_registradores.sv
// General-purpose register file: NUM_REGS x DATA_WIDTH, two asynchronous read
// ports (rs, rt) and one synchronous write port (rd). Register 0 is hardwired
// to zero. reset_n clears every register asynchronously.
// Optional macro BANCO_REGISTRADORES_BYPASS_EN enables write-to-read forwarding.
// NUM_REGS must equal 2**ADDR_WIDTH so every index is a valid register.
module banco_registradores
    import banco_registradores_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned NUM_REGS   = NUM_REGS_DEF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] rs,
    input  logic [ADDR_WIDTH-1:0] rt,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0] dado_escrita,
    output logic [DATA_WIDTH-1:0] dado_lido1,
    output logic [DATA_WIDTH-1:0] dado_lido2
);

    localparam logic [ADDR_WIDTH-1:0] IDX_ZERO = ADDR_WIDTH'(REG_ZERO);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_d;

    // Next storage state: apply the enabled write, never to register 0.
    always_comb begin
        regs_d = regs_q;
        if (RegWrite && (rd != IDX_ZERO)) begin
            regs_d[rd] = dado_escrita;
        end
        // Entry 0 is kept at zero so storage itself never holds a stale value there.
        regs_d[0] = '0;
    end

    // Storage register: asynchronous clear, otherwise capture on the rising edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    banco_registradores_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_port_rs (
        .regs    (regs_q),
        .idx     (rs),
`ifdef BANCO_REGISTRADORES_BYPASS_EN
        .wr_en   (RegWrite),
        .wr_idx  (rd),
        .wr_data (dado_escrita),
`endif
        .rdata   (dado_lido1)
    );

    banco_registradores_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_port_rt (
        .regs    (regs_q),
        .idx     (rt),
`ifdef BANCO_REGISTRADORES_BYPASS_EN
        .wr_en   (RegWrite),
        .wr_idx  (rd),
        .wr_data (dado_escrita),
`endif
        .rdata   (dado_lido2)
    );

endmodule : banco_registradores

// File: tb/tb_banco_registradores.sv
// Directed bench for banco_registradores. The driver pushes expected read data
// into a queue and raises probe; a monitor samples both read ports on the
// falling clock edge and compares against the queue.
module tb_banco_registradores;
    import banco_registradores_pkg::*;

    localparam int W = DATA_WIDTH_DEF;

    // ---------------- clock / reset ----------------
    logic     clock = 1'b0;
    logic     reset_n = 1'b0;
    logic     reg_write = 1'b0;
    reg_idx_t rs = '0;
    reg_idx_t rt = '0;
    reg_idx_t rd = '0;
    reg_data_t dado_escrita = '0;
    reg_data_t dado_lido1;
    reg_data_t dado_lido2;

    always #5 clock = ~clock;

    banco_registradores dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .RegWrite     (reg_write),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .dado_escrita (dado_escrita),
        .dado_lido1   (dado_lido1),
        .dado_lido2   (dado_lido2)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic         probe = 1'b0;
    int           n_vectors = 0;
    int           n_miscompares = 0;

    // Monitor: on the falling edge, compare both read ports against the queue.
    always @(negedge clock) begin
        if (probe) begin
            logic [W-1:0] e1;
            logic [W-1:0] e2;
            string        nm;
            if (exp_q.size() < 2 || name_q.size() < 1) begin
                n_vectors++;
                n_miscompares++;
                $display("FAIL scoreboard_underflow: probe raised with %0d expected entries", exp_q.size());
            end else begin
                e1 = exp_q.pop_front();
                e2 = exp_q.pop_front();
                nm = name_q.pop_front();
                n_vectors++;
                if (dado_lido1 !== e1) begin
                    n_miscompares++;
                    $display("FAIL %s.lido1: got 0x%08h expected 0x%08h", nm, dado_lido1, e1);
                end
                n_vectors++;
                if (dado_lido2 !== e2) begin
                    n_miscompares++;
                    $display("FAIL %s.lido2: got 0x%08h expected 0x%08h", nm, dado_lido2, e2);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic drive_write(input reg_idx_t a, input reg_data_t d);
        reg_write    = 1'b1;
        rd           = a;
        dado_escrita = d;
        @(posedge clock); #1;
        reg_write    = 1'b0;
    endtask

    // Presents rs/rt, queues expectations, lets the monitor sample at the
    // falling edge, then advances past the next rising edge.
    task automatic check_read(input string nm, input reg_idx_t a1, input reg_idx_t a2,
                              input reg_data_t e1, input reg_data_t e2);
        rs = a1;
        rt = a2;
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        name_q.push_back(nm);
        probe = 1'b1;
        @(negedge clock); #1;
        probe = 1'b0;
        @(posedge clock); #1;
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        reg_data_t same_cycle_exp;
`ifdef BANCO_REGISTRADORES_BYPASS_EN
        same_cycle_exp = 32'h1234_5678;
`else
        same_cycle_exp = 32'h0000_0000;
`endif
        // Power-up reset held: outputs read zero.
        @(posedge clock); #1;
        check_read("reset_hold", 5'd1, 5'd31, 32'h0, 32'h0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Populate 1 and 31, then clear them with a mid-cycle async reset.
        drive_write(5'd1, 32'h1111_1111);
        drive_write(5'd31, 32'hFFFF_0000);
        check_read("pre_reset", 5'd1, 5'd31, 32'h1111_1111, 32'hFFFF_0000);
        #1 reset_n = 1'b0;   // between edges, no clock edge before sampling
        check_read("async_reset", 5'd1, 5'd31, 32'h0, 32'h0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Basic write/read.
        drive_write(5'd4, 32'h0000_0008);
        check_read("wr4", 5'd4, 5'd4, 32'h0000_0008, 32'h0000_0008);
        drive_write(5'd6, 32'h0000_000F);
        check_read("wr6", 5'd6, 5'd4, 32'h0000_000F, 32'h0000_0008);

        // Write disabled.
        reg_write = 1'b0; rd = 5'd3; dado_escrita = 32'hDEAD_BEEF;
        @(posedge clock); #1;
        check_read("we_off", 5'd3, 5'd0, 32'h0, 32'h0);

        // Register 0 ignores writes.
        drive_write(5'd0, 32'hFFFF_FFFF);
        check_read("zero_reg", 5'd0, 5'd0, 32'h0, 32'h0);

        // Same-cycle read of rd: old value (or forwarded), then new value.
        reg_write = 1'b1; rd = 5'd5; dado_escrita = 32'h1234_5678;
        check_read("same_cycle", 5'd5, 5'd5, same_cycle_exp, same_cycle_exp);
        reg_write = 1'b0;
        check_read("after_edge", 5'd5, 5'd6, 32'h1234_5678, 32'h0000_000F);

        // rd=0 is never forwarded, and read 0 stays zero during a write to 0.
        reg_write = 1'b1; rd = 5'd0; dado_escrita = 32'hCAFE_F00D;
        check_read("fwd_zero", 5'd0, 5'd5, 32'h0, 32'h1234_5678);
        reg_write = 1'b0;

        // Reset mid-operation discards a coinciding write.
        drive_write(5'd10, 32'hA5A5_A5A5);
        check_read("wr10", 5'd10, 5'd10, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        reg_write = 1'b1; rd = 5'd11; dado_escrita = 32'h7777_7777;
        reset_n = 1'b0;
        @(posedge clock); #1;
        reg_write = 1'b0;
        check_read("in_reset", 5'd10, 5'd11, 32'h0, 32'h0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check_read("post_reset", 5'd10, 5'd11, 32'h0, 32'h0);

        // Writes resume after reset; earlier contents stay cleared.
        drive_write(5'd11, 32'h0BAD_F00D);
        check_read("resume", 5'd11, 5'd4, 32'h0BAD_F00D, 32'h0);

        // Final report.
        @(posedge clock); #1;
        if (exp_q.size() != 0) begin
            n_vectors++;
            n_miscompares++;
            $display("FAIL scoreboard_drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule : tb_banco_registradores

// File: doc/banco_registradores.md
Name: banco_registradores

Overview:
- Processor general-purpose register file: NUM_REGS x DATA_WIDTH storage, two asynchronous read ports (rs, rt) and one synchronous write port (rd).
- Sits in the decode/writeback path of the single-clock MIPS-style datapath.
- Register 0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, width of each register and data ports.
- ADDR_WIDTH, 5, width of register index ports.
- NUM_REGS, 32, number of registers (must equal 2**ADDR_WIDTH).

Ports:
- clock  input  1  system clock; all writes on rising edge.
- reset_n  input  1  asynchronous active-low reset; clears all registers.
- RegWrite  input  1  write enable for the write port.
- rs  input  ADDR_WIDTH  read port 1 register index.
- rt  input  ADDR_WIDTH  read port 2 register index.
- rd  input  ADDR_WIDTH  write port register index.
- dado_escrita  input  DATA_WIDTH  write data.
- dado_lido1  output  DATA_WIDTH  contents of register rs.
- dado_lido2  output  DATA_WIDTH  contents of register rt.

Behaviour:
- Reset:
  - reset_n low asynchronously forces every register to 0, independent of clock.
  - Outputs therefore read 0 while reset is held.
  - Release of reset is sampled by the next rising edge.
  - A write coinciding with active reset is discarded.
- Write:
  - On rising edge of clock with reset_n high and RegWrite=1, register[rd] <= dado_escrita.
  - The result is visible on the read ports after that edge (one-edge write latency).
- Register 0:
  - Writes with rd=0 are ignored.
  - Reads of index 0 always return 0.
- RegWrite=0: no register changes; rd and dado_escrita are don't-care.
- Reads:
  - Purely combinational: dado_lido1 = register[rs], dado_lido2 = register[rt].
  - Outputs update within the same cycle when rs/rt or register contents change.
  - No clock latency on reads.
- Both read ports may address the same register (including rd) simultaneously; both return identical values.
- Read of rd during its write cycle (without bypass):
  - Returns the old value until the rising edge.
  - Returns the new value after the edge.
- Index range: all 2**ADDR_WIDTH indices are valid; there are no out-of-range cases.
- No X propagation from storage after reset; un-reset simulation start is undefined.

Optional Feature:
- Macro BANCO_REGISTRADORES_BYPASS_EN.
- Defined: write-to-read forwarding. When RegWrite=1 and rd!=0, a read port whose index equals rd returns dado_escrita combinationally in the same cycle, before the edge. This lets writeback and decode share a cycle.
- Not defined: reads return stored contents only, as in Behaviour.
- rd=0 is never forwarded in either mode.

Decomposition:
- Package banco_registradores_pkg:
  - Constants DATA_WIDTH_DEF=32, ADDR_WIDTH_DEF=5, NUM_REGS_DEF=32, REG_ZERO=0.
  - Typedefs reg_idx_t (ADDR_WIDTH bits) and reg_data_t (DATA_WIDTH bits).
- One natural sub-module: banco_registradores_read_port, instantiated twice.
  - Inputs: storage array, index, and (when bypass is enabled) write-enable/rd/dado_escrita.
  - Implements the zero-index rule and optional forwarding mux.
- Storage and write logic stay in the top.

Test Plan:
- Reset then read: pulse reset_n low asynchronously mid-cycle; rs=1, rt=31 -> dado_lido1=0, dado_lido2=0 immediately, no edge needed.
- Basic write/read: RegWrite=1, rd=4, dado_escrita=0x00000008, one rising edge; then rs=4, rt=4 -> both outputs 0x00000008. Then rd=6, dado_escrita=0x0000000F, edge; rs=6 -> 0x0000000F while rt=4 still 0x00000008.
- Write disabled: RegWrite=0, rd=3, dado_escrita=0xDEADBEEF, edge -> register 3 still 0.
- Zero register: RegWrite=1, rd=0, dado_escrita=0xFFFFFFFF, edge; rs=0 -> 0.
- Same-cycle read of rd:
  - RegWrite=1, rd=5, dado_escrita=0x12345678, rs=5 before edge -> old value 0 without macro, 0x12345678 with BANCO_REGISTRADORES_BYPASS_EN.
  - After edge, 0x12345678 in both modes.
- Reset mid-operation: write 0xA5A5A5A5 to reg 10; assert reset_n low with RegWrite=1, rd=11 at an edge -> regs 10 and 11 read 0 after release.
